// File: rtl/add_checker.sv
// add_checker: exhaustive sweep checker for an external 4-bit adder.
// Drives all 256 operand pairs, waits SETTLE_CYCLES per pair, then compares
// the returned {cout,sum} against the exact 5-bit sum.
//   clk, rst (async, active-high)   clock / reset
//   start                           begin a sweep (honoured in IDLE or DONE)
//   num1, num2                      operands to the adder (registered)
//   dut_out, dut_cout               adder result
//   busy, done, pass                sweep status
//   err_count, first_fail(_valid)   mismatch statistics
module add_checker #(
  parameter int SETTLE_CYCLES = 1  // 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] num1,
  output logic [3:0] num2,
  input  logic [3:0] dut_out,
  input  logic       dut_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] first_fail,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic [7:0] index, index_nxt;
  logic [3:0] settle_cnt, settle_nxt;
  logic [8:0] err_nxt;
  logic [7:0] ff_nxt;
  logic       ffv_nxt, done_nxt, pass_nxt;

  logic [4:0] exp_sum;
  logic       mismatch;

  // Operands come straight from the index register.
  assign num1 = index[7:4];
  assign num2 = index[3:0];
  assign busy = (state == SETTLE) || (state == CHECK);

  assign exp_sum  = {1'b0, index[7:4]} + {1'b0, index[3:0]};
  assign mismatch = ({dut_cout, dut_out} != exp_sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      index            <= '0;
      settle_cnt       <= '0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      state            <= state_nxt;
      index            <= index_nxt;
      settle_cnt       <= settle_nxt;
      err_count        <= err_nxt;
      first_fail       <= ff_nxt;
      first_fail_valid <= ffv_nxt;
      done             <= done_nxt;
      pass             <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    index_nxt  = index;
    settle_nxt = settle_cnt;
    err_nxt    = err_count;
    ff_nxt     = first_fail;
    ffv_nxt    = first_fail_valid;
    done_nxt   = done;
    pass_nxt   = pass;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt  = SETTLE;
          index_nxt  = '0;
          settle_nxt = SETTLE_INIT;
          err_nxt    = '0;
          ff_nxt     = '0;
          ffv_nxt    = 1'b0;
          done_nxt   = 1'b0;
          pass_nxt   = 1'b0;
        end
      end
      SETTLE: begin
        settle_nxt = settle_cnt - 4'd1;
        if (settle_cnt == 4'd1) state_nxt = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          // 256 mismatches max fits in 9 bits, so no saturation needed.
          err_nxt = err_count + 9'd1;
          if (!first_fail_valid) begin
            ff_nxt  = index;
            ffv_nxt = 1'b1;
          end
        end
        if (index == 8'hFF) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == 9'd0);
        end else begin
          index_nxt  = index + 8'd1;
          settle_nxt = SETTLE_INIT;
          state_nxt  = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_add_checker.sv
module tb_add_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start3 = 1'b0;
  int   fault = 0;  // 0 ideal, 1 cout stuck-0, 2 out[0] stuck-0

  logic [3:0] n1a, n2a, outa, n1b, n2b, outb;
  logic       couta, busya, donea, passa, ffva;
  logic       coutb, busyb, doneb, passb, ffvb;
  logic [8:0] erra, errb;
  logic [7:0] ffa, ffb;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  add_checker #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .num1(n1a), .num2(n2a),
    .dut_out(outa), .dut_cout(couta), .busy(busya), .done(donea),
    .pass(passa), .err_count(erra), .first_fail(ffa), .first_fail_valid(ffva));

  add_checker #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .num1(n1b), .num2(n2b),
    .dut_out(outb), .dut_cout(coutb), .busy(busyb), .done(doneb),
    .pass(passb), .err_count(errb), .first_fail(ffb), .first_fail_valid(ffvb));

  function automatic logic [4:0] adder(input logic [3:0] a, input logic [3:0] b, input int f);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (f == 1) s[4] = 1'b0;
    else if (f == 2) s[0] = 1'b0;
    return s;
  endfunction

  always_comb {couta, outa} = adder(n1a, n2a, fault);
  always_comb {coutb, outb} = adder(n1b, n2b, fault);

  // View of whichever instance the current sweep targets.
  logic       sel = 1'b0;
  logic       m_busy, m_done, m_pass, m_ffv;
  logic [8:0] m_err;
  logic [7:0] m_ff, m_ops;
  always_comb begin
    m_busy = sel ? busyb : busya;
    m_done = sel ? doneb : donea;
    m_pass = sel ? passb : passa;
    m_ffv  = sel ? ffvb  : ffva;
    m_err  = sel ? errb  : erra;
    m_ff   = sel ? ffb   : ffa;
    m_ops  = sel ? {n1b, n2b} : {n1a, n2a};
  end

  typedef struct {
    int   cyc;
    int   err;
    logic pss;
    logic ffv;
    int   ff;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run_sweep(input logic s3, input int f, input bit hold);
    exp_t       e;
    int         cyc, run, scyc;
    logic [7:0] prev;
    sel  = s3;
    fault = f;
    scyc = s3 ? 3 : 1;
    e.err = 0; e.ffv = 1'b0; e.ff = 0;
    for (int i = 0; i < 256; i++) begin
      logic [3:0] a, b;
      logic [4:0] ideal;
      a = 4'(i >> 4);
      b = 4'(i & 15);
      ideal = 5'(int'(a) + int'(b));
      if (adder(a, b, f) != ideal) begin
        e.err++;
        if (!e.ffv) begin e.ffv = 1'b1; e.ff = i; end
      end
    end
    e.cyc = 256 * (scyc + 1);
    e.pss = (e.err == 0);
    sb.push_back(e);

    @(negedge clk);
    if (s3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
    chk("start_clear", {19'd0, m_done, m_pass, m_ffv, m_err}, 32'd0);
    chk("start_busy", {31'd0, m_busy}, 32'd1);

    cyc = 0; run = 0; prev = m_ops;
    while (!m_done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++; run++;
      if (m_ops !== prev) begin
        chk("op_hold", run, scyc + 1);
        chk("op_step", {24'd0, m_ops}, {24'd0, 8'(prev + 8'd1)});
        prev = m_ops;
        run  = 0;
      end
    end
    start1 = 1'b0; start3 = 1'b0;

    e = sb.pop_front();
    chk("latency", cyc, e.cyc);
    chk("err_count", {23'd0, m_err}, e.err);
    chk("pass", {31'd0, m_pass}, {31'd0, e.pss});
    chk("ff_valid", {31'd0, m_ffv}, {31'd0, e.ffv});
    chk("first_fail", {24'd0, m_ff}, e.ff);
    chk("busy_done", {31'd0, m_busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", {22'd0, m_done, m_err}, {22'd0, 1'b1, 9'(e.err)});
  endtask

  initial begin
    #12;
    chk("rst_a", {3'd0, busya, donea, passa, erra, ffa, ffva, n1a, n2a}, 32'd0);
    chk("rst_b", {3'd0, busyb, doneb, passb, errb, ffb, ffvb, n1b, n2b}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_sweep(1'b0, 0, 1'b0);  // ideal
    run_sweep(1'b0, 1, 1'b0);  // cout stuck -> 120 errors, first 1F
    run_sweep(1'b0, 2, 1'b1);  // out[0] stuck, start held throughout
    run_sweep(1'b0, 0, 1'b0);  // restart from DONE clears results

    // Abort mid-sweep with an asynchronous reset.
    sel = 1'b0; fault = 1;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("pre_rst_err", {23'd0, erra}, 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {3'd0, busya, donea, passa, erra, ffa, ffva, n1a, n2a}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", {30'd0, busya, donea}, 32'd0);
    run_sweep(1'b0, 0, 1'b0);

    run_sweep(1'b1, 0, 1'b0);  // SETTLE_CYCLES=3, ideal
    run_sweep(1'b1, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
